// File: rtl/ex_div_seq_if.sv
// Handshake/data bundle between the EX stage and the divide sequencer.
// The master drives requests; the slave (ex_div_seq) returns stall/busy/done/result.
interface ex_div_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1_data, rs2_data, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/ex_div_seq.sv
// Radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU (34-cycle latency).
// Optional macro EX_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish in one cycle.
module ex_div_seq #(
  parameter int unsigned XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  ex_div_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state, w_state_d;
  logic [4:0]      r_cnt, w_cnt_d;
  logic [XLEN-1:0] r_rem, w_rem_d;
  logic [XLEN-1:0] r_quo, w_quo_d;
  logic [XLEN-1:0] r_div, w_div_d;
  logic [XLEN-1:0] r_result, w_result_d;
  logic [1:0]      r_op, w_op_d;
  logic            r_qsign, w_qsign_d;
  logic            r_rsign, w_rsign_d;
  logic            r_div0, w_div0_d;
  logic            r_ovf, w_ovf_d;

  logic            w_signed, w_accept, w_in_div0, w_in_ovf;
  logic [XLEN-1:0] w_rs1_mag, w_rs2_mag;
  logic [XLEN:0]   w_rem_sh, w_trial;
  logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_quo_fin, w_rem_fin;

  assign w_signed  = ~bus.op[0];
  assign w_accept  = bus.start & ~bus.flush;
  assign w_in_div0 = (bus.rs2_data == '0);
  assign w_in_ovf  = w_signed & (bus.rs1_data == MinInt) & (bus.rs2_data == '1);
  assign w_rs1_mag = (w_signed & bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
  assign w_rs2_mag = (w_signed & bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;

  // Partial remainder is one bit wider so divisors above 2^31 cannot overflow the shift.
  assign w_rem_sh  = {r_rem, r_quo[XLEN-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_div};

  assign w_quo_fix = r_qsign ? -r_quo : r_quo;
  assign w_rem_fix = r_rsign ? -r_rem : r_rem;
  assign w_quo_fin = r_div0 ? '1 : (r_ovf ? MinInt : w_quo_fix);
  assign w_rem_fin = r_ovf ? '0 : w_rem_fix;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_rem_d    = r_rem;
    w_quo_d    = r_quo;
    w_div_d    = r_div;
    w_result_d = r_result;
    w_op_d     = r_op;
    w_qsign_d  = r_qsign;
    w_rsign_d  = r_rsign;
    w_div0_d   = r_div0;
    w_ovf_d    = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_op_d    = bus.op;
          w_div0_d  = w_in_div0;
          w_ovf_d   = w_in_ovf;
          w_qsign_d = w_signed & (bus.rs1_data[XLEN-1] ^ bus.rs2_data[XLEN-1]);
          w_rsign_d = w_signed & bus.rs1_data[XLEN-1];
          w_rem_d   = '0;
          w_quo_d   = w_rs1_mag;
          w_div_d   = w_rs2_mag;
          w_cnt_d   = 5'd31;
          w_state_d = StCalc;
`ifdef EX_DIV_EARLY_OUT_EN
          if (w_in_div0 | w_in_ovf) begin
            w_state_d  = StDone;
            w_result_d = w_in_div0 ? (bus.op[1] ? bus.rs1_data : '1)
                                   : (bus.op[1] ? '0 : MinInt);
          end
`endif
        end
      end
      StCalc: begin
        w_quo_d = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
        w_rem_d = w_trial[XLEN] ? w_rem_sh[XLEN-1:0] : w_trial[XLEN-1:0];
        w_cnt_d = r_cnt - 5'd1;
        if (r_cnt == 5'd0) w_state_d = StFix;
      end
      StFix: begin
        w_result_d = r_op[1] ? w_rem_fin : w_quo_fin;
        w_state_d  = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // Flush abandons the operation without touching the published result.
    if (bus.flush) begin
      w_state_d  = StIdle;
      w_result_d = r_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_rem    <= w_rem_d;
      r_quo    <= w_quo_d;
      r_div    <= w_div_d;
      r_result <= w_result_d;
      r_op     <= w_op_d;
      r_qsign  <= w_qsign_d;
      r_rsign  <= w_rsign_d;
      r_div0   <= w_div0_d;
      r_ovf    <= w_ovf_d;
    end
  end

  assign bus.stall  = ((r_state == StIdle) & w_accept) | (r_state == StCalc) |
                      (r_state == StFix);
  assign bus.busy   = (r_state != StIdle);
  assign bus.done   = (r_state == StDone);
  assign bus.result = r_result;

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: directed spec cases plus randomized ops vs. an
// arithmetic reference model.
module tb_ex_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_div_seq_if #(.XLEN(32)) bus ();

  ex_div_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

`ifdef EX_DIV_EARLY_OUT_EN
  localparam int SpecialLat = 1;
`else
  localparam int SpecialLat = 34;
`endif

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return SpecialLat;
    return 34;
  endfunction

  // Caller is just past a falling edge (cycle T); returns in the cycle done is seen.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stalls, output logic [31:0] res);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    #1;
    stalls = bus.stall ? 1 : 0;
    lat    = -1;
    res    = 'x;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.stall) stalls++;
      if (bus.done) begin
        lat = c;
        res = bus.result;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({bus.stall, bus.busy, bus.done} !== 3'b000 || bus.result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall/busy/done=%b%b%b result=%h required 000 / 0",
               bus.stall, bus.busy, bus.done, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_divu();
    logic [1:0]  ops [2] = '{2'd1, 2'd3};
    logic [31:0] exp [2] = '{32'd14, 32'd2};
    int lat, st;
    logic [31:0] res;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue(ops[i], 32'd100, 32'd7, lat, st, res);
      n_checks++;
      if (res !== exp[i]) begin
        n_fail++;
        $display("FAIL divu_result[%0d]: got %h required %h", i, res, exp[i]);
      end
      n_checks++;
      if (lat !== 34 || st !== 34) begin
        n_fail++;
        $display("FAIL divu_timing[%0d]: latency %0d stall cycles %0d required 34/34", i, lat,
                 st);
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL divu_busy_in_done[%0d]: got %b required 1", i, bus.busy);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp[i]) begin
        n_fail++;
        $display("FAIL divu_after_done[%0d]: done=%b busy=%b result=%h required 0/0/%h", i,
                 bus.done, bus.busy, bus.result, exp[i]);
      end
    end
  endtask

  task automatic test_signed();
    logic [1:0]  ops [2] = '{2'd0, 2'd2};
    logic [31:0] exp [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
    int lat, st;
    logic [31:0] res;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue(ops[i], 32'hFFFF_FFF9, 32'd2, lat, st, res);
      n_checks++;
      if (res !== exp[i] || lat !== 34) begin
        n_fail++;
        $display("FAIL signed[%0d]: got %h lat %0d required %h lat 34", i, res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_div0();
    logic [1:0]  ops [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
    logic [31:0] a   [4] = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'd5};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5};
    int lat, st;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(ops[i], a[i], 32'd0, lat, st, res);
      n_checks++;
      if (res !== exp[i] || lat !== SpecialLat || st !== SpecialLat) begin
        n_fail++;
        $display("FAIL div0[%0d]: got %h lat %0d stall %0d required %h lat/stall %0d", i, res,
                 lat, st, exp[i], SpecialLat);
      end
    end
  endtask

  task automatic test_overflow();
    logic [1:0]  ops [2] = '{2'd0, 2'd2};
    logic [31:0] exp [2] = '{32'h8000_0000, 32'd0};
    int lat, st;
    logic [31:0] res;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue(ops[i], 32'h8000_0000, 32'hFFFF_FFFF, lat, st, res);
      n_checks++;
      if (res !== exp[i] || lat !== SpecialLat) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got %h lat %0d required %h lat %0d", i, res, lat,
                 exp[i], SpecialLat);
      end
    end
  endtask

  task automatic test_flush();
    int fl_at [2] = '{10, 33};
    logic [31:0] prev;
    logic saw_done;
    int lat, st;
    logic [31:0] res;
    @(negedge clk);
    issue(2'd1, 32'd100, 32'd7, lat, st, res);
    prev = 32'd14;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.start    = 1'b1;
      bus.op       = 2'd1;
      bus.rs1_data = 32'd1000;
      bus.rs2_data = 32'd7;
      saw_done     = 1'b0;
      for (int c = 1; c <= fl_at[k]; c++) begin
        @(negedge clk);
        bus.start = 1'b0;
        if (c == fl_at[k]) bus.flush = 1'b1;
        #1;
        if (bus.done) saw_done = 1'b1;
      end
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0 || saw_done) begin
        n_fail++;
        $display("FAIL flush_idle[%0d]: busy=%b stall=%b done=%b saw_done=%b required 0/0/0/0",
                 k, bus.busy, bus.stall, bus.done, saw_done);
      end
      n_checks++;
      if (bus.result !== prev) begin
        n_fail++;
        $display("FAIL flush_result_kept[%0d]: got %h required %h", k, bus.result, prev);
      end
      issue(2'd1, 32'd9, 32'd3, lat, st, res);
      n_checks++;
      if (res !== 32'd3 || lat !== 34) begin
        n_fail++;
        $display("FAIL flush_restart[%0d]: got %h lat %0d required 3 lat 34", k, res, lat);
      end
      prev = 32'd3;
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done = 1'b0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = 2'd1;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.stall, bus.busy, bus.done} !== 3'b000 || bus.result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: stall/busy/done=%b%b%b result=%h required 000 / 0",
               bus.stall, bus.busy, bus.done, bus.result);
    end
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.busy || bus.done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy/done seen=1 required 0");
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, res;
    int lat, st;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'($urandom_range(0, 255)); b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); end
        default: ;
      endcase
      @(negedge clk);
      issue(op, a, b, lat, st, res);
      n_checks++;
      if (res !== ref_result(op, a, b) || lat !== ref_lat(op, a, b)) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d required %h lat %0d", i,
                 op, a, b, res, lat, ref_result(op, a, b), ref_lat(op, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [3] = '{2'd0, 2'd3, 2'd2};
    logic [31:0] a   [3] = '{32'd1000, 32'hDEAD_BEEF, 32'hFFFF_FC18};
    logic [31:0] b   [3] = '{32'hFFFF_FFF9, 32'h0001_0003, 32'd33};
    logic [31:0] res;
    int lat, st;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      issue(ops[i], a[i], b[i], lat, st, res);
      n_checks++;
      if (res !== ref_result(ops[i], a[i], b[i]) || lat !== 34) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h lat %0d required %h lat 34", i, res, lat,
                 ref_result(ops[i], a[i], b[i]));
      end
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.op       = 2'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    bus.flush    = 1'b0;
    test_reset();
    test_divu();
    test_signed();
    test_div0();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Multi-cycle divide sequencer for the EX stage. It executes RV32M DIV/DIVU/REM/REMU with a radix-2 restoring algorithm at one quotient bit per cycle. While it runs, it holds the pipeline through `stall`. The single-cycle ALU keeps all other ops; this block owns only the four divide ops and hands its result to the EX result mux on a one-cycle `done` pulse.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  request from decode/EX; sampled only in IDLE.
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start`.
- `rs1_data`  in  32  dividend; sampled with `start`.
- `rs2_data`  in  32  divisor; sampled with `start`.
- `flush`  in  1  pipeline flush (branch taken / trap); aborts the operation.
- `stall`  out  1  holds IF/ID/EX registers.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid while it is high.
- `result`  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On `start & ~flush`, latch `op` and the operands.
  - For signed ops, store the operand magnitudes and record the quotient sign (`rs1[31]^rs2[31]`) and the remainder sign (`rs1[31]`).
  - Load bit counter = 31 and go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left one bit.
  - Form `trial = rem - divisor` as 33-bit unsigned.
  - If `trial` is non-negative: rem = trial[31:0] and quo[0] = 1; otherwise quo[0] = 0.
  - Decrement the counter. At count 0 the final iteration executes and the state goes to FIX.
- FIX:
  - Apply sign correction: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Select the result by `op`, register it and go to DONE.
- DONE: `done=1` for one cycle, then go to IDLE.
- Special cases (RISC-V mandated values):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend, for both signed and unsigned ops.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Without the configuration macro, these cases still run the full CALC sequence and FIX forces the mandated values.
- Flush: in any state, `flush` sends the block to IDLE on the next edge with no `done` pulse and `result` unchanged. If `flush` and `start` are high in the same cycle, `flush` wins and the request is dropped.
- `start` while busy is ignored; the issuing logic holds `start` under `stall`.
- Reset mid-operation: immediate return to IDLE; all outputs go to their reset values.

## Timing
- Reset values: state IDLE, `stall=0`, `busy=0`, `done=0`, `result=0`; internal counters and operand registers are 0.
- `start` accepted in cycle T:
  - CALC occupies T+1..T+32.
  - FIX is T+33.
  - DONE is T+34 (`done=1`, `result` valid).
  - Nominal latency is 34 cycles.
- `stall` (combinational) = `(IDLE & start & ~flush) | CALC | FIX`:
  - High from T through T+33.
  - Low in T+34, so the pipeline advances and the EX/MEM register captures `result` on the edge that ends T+34.
- `busy` is registered from the state: high T+1..T+34.
- Back-to-back: a new `start` is accepted at the earliest in T+35, when the block is in IDLE again.
- `result` holds its value after DONE until the next FIX.

## Configuration
- Macro `EX_DIV_EARLY_OUT_EN` defined: in IDLE, a special-case divisor or overflow skips CALC and FIX and goes directly to DONE with the mandated value.
  - `done` is asserted in T+1; `stall` is high in T only.
- Macro undefined: every operation takes 34 cycles with identical results.

## Test plan
- DIVU 100 / 7: `done` at T+34, `result`=14; REMU with the same operands gives `result`=2; `stall` high for exactly 34 cycles.
- DIV -7 (0xFFFFFFF9) / 2 gives `result`=0xFFFFFFFD (-3); REM with the same operands gives 0xFFFFFFFF (-1).
- DIVU 5 / 0 gives 0xFFFFFFFF, and REM 5 / 0 gives 5.
  - Macro undefined: `done` at T+34.
  - Macro defined: `done` at T+1.
- DIV 0x80000000 / 0xFFFFFFFF gives `result`=0x80000000; REM with the same operands gives 0.
- `flush` asserted at T+10:
  - IDLE at T+11 with `busy=0`, `stall=0`, and no `done` pulse.
  - A new DIVU 9 / 3 started at T+11 gives `done` at T+45 with `result`=3.
- `rst_n` low at T+20: outputs go to 0 immediately and remain IDLE after release; `start` during reset is ignored.
